// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply (LSB first) and
// restoring divide (MSB first), one bit per cycle, registered result with done pulse.
module seq_muldiv_unit #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [size-1:0] src1_i,
    input  logic [size-1:0] src2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [size-1:0] result_o
);

    localparam int CW = (size > 1) ? $clog2(size) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [size-1:0]     a_q, a_d;
    logic [size-1:0]     b_q, b_d;
    logic [2*size-1:0]   acc_q, acc_d;
    logic [size-1:0]     result_q, result_d;

    logic                last_iter;
    logic [size:0]       mul_sum;
    logic [size:0]       div_shift;
    logic [size:0]       div_diff;
    logic                div_ge;

    assign last_iter = (cnt_q == CW'(size - 1));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode straight from the state register
    always_comb begin
        busy_o   = (state_q == S_RUN);
        done_o   = (state_q == S_DONE);
        result_o = result_q;
    end

    // Multiply: acc holds the running 2*size product; the upper half accumulates
    // and the whole thing shifts right, while b_q feeds multiplier bits LSB first.
    // Divide: a_q shifts the dividend out of its MSB while quotient bits shift in
    // at the LSB; acc[size-1:0] holds the partial remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*size-1:size]} + (b_q[0] ? {1'b0, a_q} : {(size+1){1'b0}});
        div_shift = {acc_q[size-1:0], a_q[size-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift - {1'b0, b_q};

        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d  = op_i;
                    a_d   = src1_i;
                    b_d   = src2_i;
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (!op_q[1]) begin
                    acc_d = {mul_sum, acc_q[size-1:1]};
                    b_d   = b_q >> 1;
                end else begin
                    acc_d[size-1:0] = div_ge ? div_diff[size-1:0] : div_shift[size-1:0];
                    a_d             = {a_q[size-2:0], div_ge};
                end
                if (last_iter) begin
                    case (op_q)
                        2'b00:   result_d = acc_d[size-1:0];
                        2'b01:   result_d = acc_d[2*size-1:size];
                        2'b10:   result_d = a_d;
                        default: result_d = acc_d[size-1:0];
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed bench for seq_muldiv_unit: hand-computed results, latency,
// start-while-busy and asynchronous reset abort.
module tb_seq_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    seq_muldiv_unit #(.size(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cycles;
        int busy_bad;
        @(negedge clk_i);
        op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        src1_i = $urandom; src2_i = $urandom; op_i = 2'($urandom);
        cycles = 0; busy_bad = 0;
        while (!done_o && cycles < 100) begin
            if (!busy_o) busy_bad++;
            @(posedge clk_i); #1;
            cycles++;
        end
        check({tag, ".latency"}, 64'(cycles), 64'd32);
        check({tag, ".busy_run"}, 64'(busy_bad), 64'd0);
        check({tag, ".result"}, 64'(result_o), 64'(exp));
        check({tag, ".busy_at_done"}, 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        check({tag, ".done_cleared"}, 64'(done_o), 64'd0);
        check({tag, ".result_held"}, 64'(result_o), 64'(exp));
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int done_cyc;
        int busy_after;
        logic [31:0] done_res;

        #1;
        check("reset.busy", 64'(busy_o), 64'd0);
        check("reset.done", 64'(done_o), 64'd0);
        check("reset.result", 64'(result_o), 64'd0);
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;

        run_op("mul_lo_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A);
        run_op("mul_hi_ffff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_lo_ffff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("div_q_100_7", 2'b10, 32'd100, 32'd7, 32'h0000_000E);
        run_op("div_r_100_7", 2'b11, 32'd100, 32'd7, 32'h0000_0002);
        run_op("div0_q", 2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op("div0_r", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678);

        // Start pulse and operand change during RUN must be ignored
        @(negedge clk_i);
        op_i = 2'b00; src1_i = 32'd3; src2_i = 32'd5; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc = 0; done_cnt = 0; done_cyc = 0; busy_after = 0; done_res = '0;
        while (cyc < 45) begin
            @(posedge clk_i); #1;
            cyc++;
            if (cyc == 9) begin
                start_i = 1'b1; src1_i = 32'd9; src2_i = 32'd9; op_i = 2'b01;
            end
            if (cyc == 10) begin
                start_i = 1'b0; src1_i = 32'd11; src2_i = 32'd13;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                done_res = result_o;
            end
            if (cyc > 32 && busy_o) busy_after++;
        end
        check("busy_start.done_count", 64'(done_cnt), 64'd1);
        check("busy_start.done_cycle", 64'(done_cyc), 64'd32);
        check("busy_start.result", 64'(done_res), 64'h0000_000F);
        check("busy_start.no_second_op", 64'(busy_after), 64'd0);

        // Asynchronous reset between E15 and E16 of a divide
        @(negedge clk_i);
        op_i = 2'b10; src1_i = 32'd1000; src2_i = 32'd3; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc = 0;
        while (cyc < 15) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        check("rst_mid.busy_before", 64'(busy_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_mid.busy", 64'(busy_o), 64'd0);
        check("rst_mid.done", 64'(done_o), 64'd0);
        check("rst_mid.result", 64'(result_o), 64'd0);
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        done_cnt = 0; busy_after = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o) done_cnt++;
            if (busy_o) busy_after++;
        end
        check("rst_mid.no_done_after", 64'(done_cnt), 64'd0);
        check("rst_mid.idle_after", 64'(busy_after), 64'd0);
        run_op("after_rst_div_q", 2'b10, 32'd100, 32'd7, 32'h0000_000E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_muldiv_unit.md
# seq_muldiv_unit

Iterative 32-cycle unsigned multiply/divide unit for the single-cycle CPU datapath. It accepts a start pulse with two operands and an operation code. It computes a multiply-low, multiply-high, quotient or remainder, then presents the registered result with a one-cycle done pulse. `result_o` feeds the write-back 3-to-1 select as an extra result source. The control unit stalls the PC while `busy_o` is high.

## Interface
- `size`, default 32: operand/result width; iteration count equals `size`.

- `clk_i`  input  1: clock, rising-edge active.
- `rst_i`  input  1: asynchronous, active-high reset.
- `start_i`  input  1: request; sampled only in IDLE.
- `op_i`  input  2: operation. 00 = MUL low, 01 = MUL high, 10 = DIV quotient, 11 = DIV remainder.
- `src1_i`  input  size: multiplicand / dividend.
- `src2_i`  input  size: multiplier / divisor.
- `busy_o`  output  1: high while iterating.
- `done_o`  output  1: one-cycle pulse; `result_o` is valid.
- `result_o`  output  size: last completed result, held until the next completion.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start_i`=1.
  - RUN→DONE after iteration `size`-1.
  - DONE→IDLE unconditionally.
- On accept: capture `op_i`, `src1_i` and `src2_i` into internal registers; clear the iteration counter and the accumulator.
  - Inputs may change freely after the accept edge.
- `start_i` in RUN or DONE is ignored. It is not queued.
- Multiply: shift-add, one multiplier bit per cycle, LSB first. Keep a 2×`size` product.
  - op 00 returns `product[size-1:0]`.
  - op 01 returns `product[2*size-1:size]`.
- Divide: restoring, one quotient bit per cycle, MSB first.
  - Shift the partial remainder left by 1 and bring in the next dividend bit.
  - If the remainder ≥ divisor: subtract and set the quotient bit to 1. Otherwise set it to 0.
  - The compare/subtract uses `size`+1 bits, so there is no overflow.
- Divide by zero needs no special path. It naturally yields quotient = all ones and remainder = dividend, and still takes `size` cycles.
- All arithmetic is unsigned. No sign handling.
- `result_o` is written only on the RUN→DONE edge.
- `busy_o` = (state==RUN). `done_o` = (state==DONE). Both are registered-state decodes, with no combinational path from the inputs.

## Timing
- Reset values:
  - state IDLE
  - `busy_o`=0, `done_o`=0, `result_o`=0
  - counter 0, internal operand/accumulator registers 0
- Reset is asynchronous. Asserting it mid-RUN aborts the operation immediately. No done pulse follows, and `result_o` returns to 0.
- Accept edge E0 (IDLE, `start_i`=1):
  - `busy_o`=1 after E0.
  - Iterations occur on edges E1..E32 (for `size`=32).
  - At E32: `result_o` is loaded, `busy_o`→0, `done_o`→1.
  - At E33: `done_o`→0, back to IDLE.
- Latency: `done_o` is visible 32 cycles after the accept edge. Issue interval is 34 cycles minimum. A start asserted during DONE is lost; the next start is accepted at E34 at the earliest.
- A `start_i` held high continuously causes back-to-back operations every 34 cycles, with operands resampled at each accept.

## Test plan
- MUL low: src1=7, src2=6, op=00, start at E0 → `busy_o` high E0..E32, `done_o` single pulse after E32, `result_o`=0x0000002A.
- MUL high/low: src1=src2=0xFFFFFFFF.
  - op=01 → `result_o`=0xFFFFFFFE.
  - Rerun with op=00 → 0x00000001.
- DIV: src1=100, src2=7.
  - op=10 → `result_o`=0x0000000E.
  - op=11 → 0x00000002.
- Divide by zero: src1=0x12345678, src2=0.
  - op=10 → 0xFFFFFFFF.
  - op=11 → 0x12345678.
  - Both take 32 cycles.
- Start-while-busy and operand change:
  - Start op=00 with 3×5.
  - At E10, pulse start with other operands and change `src1_i`/`src2_i`.
  - Required: result 0x0000000F at E32, exactly one `done_o` pulse, no second operation begins.
- Reset mid-operation: assert `rst_i` asynchronously between E15 and E16 of a DIV.
  - `busy_o`, `done_o` and `result_o` go to 0 immediately; no `done_o` afterward.
  - A new start after release completes normally with the correct result.
